// File: rtl/deserializer_stream_pkg.sv
// Shared types and elaboration helpers for the stream deserializer.
package deserializer_pkg;

    typedef enum logic {ACCUM, FULL} state_t;

    function automatic int seg_count_w(input int num_seg);
        return $clog2(num_seg + 1);
    endfunction

    // Output width must be a whole number (>= 2) of input segments.
    function automatic bit ratio_ok(input int in_w, input int out_w);
        return (in_w > 0) && (out_w % in_w == 0) && (out_w / in_w >= 2);
    endfunction

endpackage

// File: rtl/deserializer_stream_if.sv
// Producer-side and consumer-side handshake bundle of the stream deserializer.
interface deserializer_stream_if
    import deserializer_pkg::*;
#(
    parameter int in_bit_width  = 32,
    parameter int out_bit_width = 512
);
    localparam int NUM_SEG = out_bit_width / in_bit_width;
    localparam int CW      = seg_count_w(NUM_SEG);

    logic                     in_valid;
    logic                     in_ready;
    logic [in_bit_width-1:0]  data_in;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [out_bit_width-1:0] data_out;
    logic [CW-1:0]            out_count;

    modport slave (
        input  in_valid, data_in, flush, out_ready,
        output in_ready, out_valid, data_out, out_count
    );

    modport master (
        output in_valid, data_in, flush, out_ready,
        input  in_ready, out_valid, data_out, out_count
    );

endinterface

// File: rtl/deserializer_stream.sv
// Packs in_bit_width segments into out_bit_width words with valid/ready on both
// sides, selectable segment order and flush of a partial word.
module deserializer_stream
    import deserializer_pkg::*;
#(
    parameter int in_bit_width  = 32,
    parameter int out_bit_width = 512
) (
    input  logic clk,
    input  logic reset,
    input  logic msb_first,
    output logic busy,
    deserializer_stream_if.slave bus
);

    localparam int NUM_SEG = out_bit_width / in_bit_width;
    localparam int CW      = seg_count_w(NUM_SEG);
    localparam int PW      = $clog2(NUM_SEG);

    generate
        if (!ratio_ok(in_bit_width, out_bit_width)) begin : g_ratio_err
            $error("deserializer_stream: out_bit_width must be a multiple >= 2 of in_bit_width");
        end
    endgenerate

    state_t                   state_reg;
    logic [CW-1:0]            count_reg;
    logic [out_bit_width-1:0] acc_reg;
    logic                     out_valid_reg;
    logic [out_bit_width-1:0] data_out_reg;
    logic [CW-1:0]            out_count_reg;
    logic                     flush_pend_reg;

    logic                     in_ready;
    logic                     accept;
    logic                     slot_free;
    logic                     last_seg;
    logic                     flush_req;
    logic [PW-1:0]            pos;
    logic [CW-1:0]            count_next;
    logic [out_bit_width-1:0] acc_next;

    assign in_ready   = (state_reg == ACCUM);
    assign accept     = bus.in_valid && in_ready;
    assign slot_free  = !out_valid_reg || bus.out_ready;
    assign count_next = count_reg + CW'(accept);
    assign last_seg   = accept && (count_reg == CW'(NUM_SEG - 1));
    assign flush_req  = bus.flush || flush_pend_reg;
    assign pos        = msb_first ? (PW'(NUM_SEG - 1) - count_reg[PW-1:0])
                                  : count_reg[PW-1:0];

    // Accumulator with the incoming segment merged at its slot; equals acc_reg
    // when nothing is accepted, so it is safe to load unconditionally.
    generate
        for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
            assign acc_next[gi*in_bit_width +: in_bit_width] =
                (accept && (pos == PW'(gi))) ? bus.data_in
                                             : acc_reg[gi*in_bit_width +: in_bit_width];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ACCUM;
            count_reg      <= '0;
            acc_reg        <= '0;
            out_valid_reg  <= 1'b0;
            data_out_reg   <= '0;
            out_count_reg  <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            // A consumed word drops out_valid unless a new word loads below.
            if (out_valid_reg && bus.out_ready)
                out_valid_reg <= 1'b0;

            case (state_reg)
                ACCUM: begin
                    if (last_seg) begin
                        if (slot_free) begin
                            out_valid_reg  <= 1'b1;
                            data_out_reg   <= acc_next;
                            out_count_reg  <= CW'(NUM_SEG);
                            count_reg      <= '0;
                            acc_reg        <= '0;
                            flush_pend_reg <= 1'b0;
                        end else begin
                            acc_reg        <= acc_next;
                            count_reg      <= count_next;
                            flush_pend_reg <= flush_req;
                            state_reg      <= FULL;
                        end
                    end else if (flush_req) begin
                        if (count_next == '0) begin
                            flush_pend_reg <= 1'b0;
                        end else if (slot_free) begin
                            out_valid_reg  <= 1'b1;
                            data_out_reg   <= acc_next;
                            out_count_reg  <= count_next;
                            count_reg      <= '0;
                            acc_reg        <= '0;
                            flush_pend_reg <= 1'b0;
                        end else begin
                            acc_reg        <= acc_next;
                            count_reg      <= count_next;
                            flush_pend_reg <= 1'b1;
                        end
                    end else begin
                        acc_reg   <= acc_next;
                        count_reg <= count_next;
                    end
                end

                FULL: begin
                    // Nothing remains after the full word leaves, so a held flush dies here.
                    if (slot_free) begin
                        out_valid_reg  <= 1'b1;
                        data_out_reg   <= acc_reg;
                        out_count_reg  <= CW'(NUM_SEG);
                        count_reg      <= '0;
                        acc_reg        <= '0;
                        flush_pend_reg <= 1'b0;
                        state_reg      <= ACCUM;
                    end else begin
                        flush_pend_reg <= flush_req;
                    end
                end

                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.data_out  = data_out_reg;
    assign bus.out_count = out_count_reg;
    assign busy          = (count_reg != '0) || (state_reg == FULL) || out_valid_reg;

endmodule

// File: tb/tb_deserializer_stream.sv
// Self-checking bench: directed vector table, corner sequences and a random
// run checked by a segment-queue scoreboard.
module tb_deserializer_stream;
    import deserializer_pkg::*;

    localparam int IW = 32;
    localparam int OW = 512;
    localparam int NS = OW / IW;
    localparam int CW = seg_count_w(NS);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic msb_first = 1'b0;
    logic busy;

    deserializer_stream_if #(.in_bit_width(IW), .out_bit_width(OW)) bus ();

    deserializer_stream #(.in_bit_width(IW), .out_bit_width(OW)) dut (
        .clk       (clk),
        .reset     (reset),
        .msb_first (msb_first),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int words_seen = 0;
    int flushes = 0;
    logic [IW-1:0] seg_q[$];
    logic          hold_chk = 1'b0;
    logic [OW-1:0] hold_dat;
    logic [CW-1:0] hold_cnt;

    typedef struct {
        logic          iv;
        logic [IW-1:0] d;
        logic          fl;
        logic          orr;
        logic          e_ov;
        logic          e_ir;
        logic          e_busy;
        logic [CW-1:0] e_oc;
        logic [OW-1:0] e_dat;
    } vec_t;

    vec_t vec[14];

    function automatic logic [OW-1:0] mk_word(input int n, input int base, input bit msb);
        logic [OW-1:0] w = '0;
        for (int k = 0; k < n; k++) begin
            int slot = msb ? (NS - 1 - k) : k;
            w[slot*IW +: IW] = IW'(base + k);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Word leaving the block must be the next out_count accepted segments, in order.
    task automatic consume_word();
        logic [OW-1:0] exp_w = '0;
        int n = int'(bus.out_count);
        bit ok = 1'b1;
        total++;
        if (n == 0 || n > NS) ok = 1'b0;
        if (n < NS && flushes == 0) ok = 1'b0;
        for (int k = 0; k < NS; k++) begin
            int slot = msb_first ? (NS - 1 - k) : k;
            if (k < n) begin
                if (seg_q.size() == 0) ok = 1'b0;
                else exp_w[slot*IW +: IW] = seg_q.pop_front();
            end
        end
        if (bus.data_out !== exp_w) ok = 1'b0;
        if (!ok) begin
            bad++;
            $display("FAIL word%0d: count=%0d data=%0h want data=%0h", words_seen, n, bus.data_out, exp_w);
        end
        words_seen++;
    endtask

    task automatic tick();
        if (hold_chk) begin
            total++;
            if (!(bus.out_valid === 1'b1 && bus.data_out === hold_dat && bus.out_count === hold_cnt)) begin
                bad++;
                $display("FAIL hold: ov=%0b cnt=%0d data=%0h want cnt=%0d data=%0h",
                         bus.out_valid, bus.out_count, bus.data_out, hold_cnt, hold_dat);
            end
        end
        hold_chk = bus.out_valid && !bus.out_ready;
        hold_dat = bus.data_out;
        hold_cnt = bus.out_count;
        if (bus.in_valid && bus.in_ready) seg_q.push_back(bus.data_in);
        if (bus.flush) flushes++;
        if (bus.out_valid && bus.out_ready) consume_word();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int next_d;
        int w0;
        bit acc;

        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        #1 reset = 1'b0;
        #1;
        check("rst_ov",   OW'(bus.out_valid), OW'(0));
        check("rst_ir",   OW'(bus.in_ready),  OW'(1));
        check("rst_busy", OW'(busy),          OW'(0));
        check("rst_oc",   OW'(bus.out_count), OW'(0));
        check("rst_data", bus.data_out,       OW'(0));
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // vector table: 5 segments + flush, stall, empty flush, flush on accept edge
        vec[0]  = '{1'b1, 32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[1]  = '{1'b1, 32'd1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[2]  = '{1'b1, 32'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[3]  = '{1'b1, 32'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[4]  = '{1'b1, 32'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[5]  = '{1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, CW'(5), mk_word(5, 0, 1'b0)};
        vec[6]  = '{1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, CW'(5), mk_word(5, 0, 1'b0)};
        vec[7]  = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CW'(0), '0};
        vec[8]  = '{1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, CW'(0), '0};
        vec[9]  = '{1'b1, 32'd10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[10] = '{1'b1, 32'd11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[11] = '{1'b1, 32'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CW'(0), '0};
        vec[12] = '{1'b1, 32'd13, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, CW'(4), mk_word(4, 10, 1'b0)};
        vec[13] = '{1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CW'(0), '0};
        for (int i = 0; i < 14; i++) begin
            bus.in_valid  = vec[i].iv;
            bus.data_in   = vec[i].d;
            bus.flush     = vec[i].fl;
            bus.out_ready = vec[i].orr;
            tick();
            bus.flush = 1'b0;
            ok = (bus.out_valid === vec[i].e_ov) && (bus.in_ready === vec[i].e_ir) && (busy === vec[i].e_busy);
            if (vec[i].e_ov)
                ok = ok && (bus.out_count === vec[i].e_oc) && (bus.data_out === vec[i].e_dat);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL vec%0d: ov=%0b ir=%0b busy=%0b cnt=%0d data=%0h want ov=%0b ir=%0b busy=%0b cnt=%0d data=%0h",
                         i, bus.out_valid, bus.in_ready, busy, bus.out_count, bus.data_out,
                         vec[i].e_ov, vec[i].e_ir, vec[i].e_busy, vec[i].e_oc, vec[i].e_dat);
            end
        end
        bus.in_valid = 1'b0;

        // LSB-first continuous stream of 256 segments
        begin
            bit timing_ok = 1'b1;
            bit ir_ok = 1'b1;
            w0 = words_seen;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            for (int i = 0; i < 256; i++) begin
                bus.data_in = IW'(i);
                if (bus.in_ready !== 1'b1) ir_ok = 1'b0;
                tick();
                if (bus.out_valid !== ((i % 16) == 15)) timing_ok = 1'b0;
            end
            bus.in_valid = 1'b0;
            tick();
            check("stream_in_ready", OW'(ir_ok), OW'(1));
            check("stream_timing",   OW'(timing_ok), OW'(1));
            check("stream_words",    OW'(words_seen - w0), OW'(16));
        end

        // MSB-first word
        msb_first = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < NS; k++) begin
            bus.data_in = IW'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        check("msb_top", OW'(bus.data_out[OW-1 -: IW]), OW'(0));
        check("msb_bot", OW'(bus.data_out[IW-1:0]),     OW'(15));
        check("msb_cnt", OW'(bus.out_count),            OW'(NS));
        bus.out_ready = 1'b1;
        tick();
        msb_first = 1'b0;
        tick();

        // consumer stalled 40 cycles after the first word: second word parks in FULL
        next_d = 1000;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = IW'(next_d);
        for (int c = 0; c < 56; c++) begin
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) next_d++;
            bus.data_in = IW'(next_d);
        end
        check("stall_in_ready", OW'(bus.in_ready),       OW'(0));
        check("stall_busy",     OW'(busy),               OW'(1));
        check("stall_word0",    OW'(bus.data_out[IW-1:0]), OW'(1000));
        check("stall_accepted", OW'(next_d - 1000),      OW'(32));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("stall_word1",    OW'(bus.data_out[IW-1:0]), OW'(1016));
        check("stall_ir_back",  OW'(bus.in_ready),       OW'(1));
        tick();

        // flush raised while the output is stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < NS + 3; k++) begin
            bus.data_in = IW'(2000 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        check("stfl_held_cnt", OW'(bus.out_count), OW'(NS));
        bus.out_ready = 1'b1;
        tick();
        check("stfl_ov",   OW'(bus.out_valid), OW'(1));
        check("stfl_cnt",  OW'(bus.out_count), OW'(3));
        check("stfl_data", bus.data_out,       mk_word(3, 2016, 1'b0));
        tick();

        // reset after 7 segments discards the partial word
        bus.in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.data_in = IW'(3000 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_ov",   OW'(bus.out_valid), OW'(0));
        check("midrst_busy", OW'(busy),          OW'(0));
        seg_q.delete();
        hold_chk = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < NS; k++) begin
            bus.data_in = IW'(4000 + k);
            tick();
        end
        bus.in_valid = 1'b0;
        check("postrst_cnt",  OW'(bus.out_count), OW'(NS));
        check("postrst_data", bus.data_out,       mk_word(NS, 4000, 1'b0));
        bus.out_ready = 1'b1;
        tick();

        // random traffic, one phase per segment order
        for (int ph = 0; ph < 2; ph++) begin
            msb_first = ph[0];
            tick();
            for (int c = 0; c < 1500; c++) begin
                bus.in_valid  = ($urandom % 4) != 0;
                bus.data_in   = $urandom;
                bus.flush     = ($urandom % 23) == 0;
                bus.out_ready = ($urandom % 3) != 0;
                tick();
            end
            bus.in_valid  = 1'b0;
            bus.flush     = 1'b0;
            bus.out_ready = 1'b1;
            for (int c = 0; c < 3; c++) tick();
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            for (int c = 0; c < 3; c++) tick();
            check("rand_drained", OW'(seg_q.size()), OW'(0));
            check("rand_idle",    OW'(busy),         OW'(0));
        end
        msb_first = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deserializer_stream.md
Name: deserializer_stream

Overview:
- Parametrised successor to the fixed-ratio deserializer.
- Packs a stream of in_bit_width segments into out_bit_width words.
- Adds valid/ready handshakes with backpressure on both sides, selectable segment order, and flush of a partial word with a valid-segment count.
- Sits between a narrow link/FIFO producer and a wide datapath consumer in the SerDes receive path.

Parameters:
- in_bit_width, 32, width of one input segment.
- out_bit_width, 512, width of the output word. Must be an integer multiple of in_bit_width, with ratio NUM_SEG = out_bit_width/in_bit_width >= 2. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (low = reset).
- msb_first  input  1  segment order. 0: segment k lands at data_out[k*in +: in]. 1: segment k lands at data_out[(NUM_SEG-1-k)*in +: in]. Quasi-static; change only while idle (count 0, out_valid 0).
- in_valid  input  1  data_in holds a segment.
- in_ready  output  1  block accepts a segment this cycle.
- data_in  input  in_bit_width  input segment.
- flush  input  1  request emission of the partial word.
- out_valid  output  1  data_out/out_count hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- data_out  output  out_bit_width  assembled word.
- out_count  output  $clog2(NUM_SEG+1)  number of valid segments in data_out (NUM_SEG for a full word).
- busy  output  1  count != 0, or state FULL, or out_valid.

Behaviour:
- Handshakes:
  - Segment accepted on a rising edge with in_valid && in_ready.
  - Word consumed on a rising edge with out_valid && out_ready.
  - out_valid, data_out and out_count are registered and stable while out_valid && !out_ready.
  - in_ready does not depend on in_valid.
- Reset (async assert, sync release): state ACCUM, count=0, accumulator=0, out_valid=0, data_out=0, out_count=0, flush_pend=0, in_ready=1.
- Output slot free ("slot_free") when !out_valid || out_ready.
- State ACCUM:
  - in_ready=1.
  - On accept with count<NUM_SEG-1: write the segment at its position; count++.
  - On accept of segment NUM_SEG-1:
    - If slot_free: load data_out with the full word (this segment merged) and out_count=NUM_SEG. out_valid=1 next cycle; count=0; accumulator cleared; stay in ACCUM.
    - Otherwise: store the segment and go to FULL.
- State FULL:
  - in_ready=0.
  - When slot_free: transfer the accumulator to the output with out_count=NUM_SEG; count=0; accumulator cleared; go to ACCUM.
- Latency and throughput:
  - Last segment accepted at edge t -> out_valid=1 after edge t.
  - With out_ready held 1, sustained one segment per cycle, no bubbles.
- Flush:
  - flush is sampled each edge and sets sticky flush_pend.
  - Pending flush is serviced in ACCUM when count_eff>0 and slot_free.
    - count_eff is count plus 1 if a segment is accepted the same edge.
    - That segment is included in the partial word.
  - Service: data_out = accumulator (unfilled segments zero), out_count=count_eff, count=0, flush_pend cleared.
  - If count_eff==NUM_SEG, the flush is absorbed by the normal full-word emission and cleared.
  - Flush with count_eff==0 clears flush_pend with no output.
  - Flush in FULL is held until the full word transfers, then cleared (nothing left).
  - in_ready stays 1 during a pending flush.
- Simultaneous consume and load on the same edge: new word replaces the old one; out_valid stays 1.
- Reset mid-word: partial data discarded, no output.

Decomposition:
- Package deserializer_pkg:
  - Function seg_count_w(num_seg) returning $clog2(num_seg+1).
  - State enum state_t {ACCUM, FULL}.
  - Elaboration check macro or function for the width ratio.
- Single module. The accumulator/position logic is small; no sub-module is required.

Test Plan (in=32, out=512, NUM_SEG=16 unless noted):
- LSB-first stream, in_valid=1 and out_ready=1 constant, data i=0..255 -> 16 words, one per 16 cycles. Word w has data_out[32*k +: 32]=16w+k, out_count=16. in_ready never drops.
- msb_first=1, segments 0..15 -> data_out[511:480]=0, data_out[31:0]=15.
- out_ready=0 for 40 cycles after the first word:
  - word 0 held stable.
  - Second word fills, state FULL, in_ready=0.
  - Raising out_ready -> word 0 consumed, then word 1 valid with 16..31. No segment lost or duplicated.
- 5 segments (0..4) then flush pulse -> out_valid next cycle, out_count=5, data_out[159:0]=4,3,2,1,0 in slots 4..0, upper bits 0. Flush with count=0 -> no output.
- Flush on the same edge as accepting segment 3 (count 3 before) -> out_count=4 including the new segment. Flush while out_valid is stalled -> emitted after consume.
- Reset asserted after 7 segments -> out_valid=0, busy=0 immediately. After release, the next 16 segments form a clean word.
